// File: rtl/process_tx_bit_pkg.sv
// process_tx_bit_pkg: control codes, line constants and FSM states for the SIE transmit bit engine
package process_tx_bit_pkg;
  localparam logic [7:0] DATA_START = 8'h00;
  localparam logic [7:0] DATA_STOP = 8'h01;
  localparam logic [7:0] DATA_STREAM = 8'h02;
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [2:0] MAX_ONES = 3'd6;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [1:0] EOP_SE0_BITS = 2'd2;
  typedef enum logic [2:0] {IDLE, LOAD, SEND_BIT, STUFF, EOP_SE0, EOP_J, UNDERRUN_WAIT} txState_t;
endpackage

// File: rtl/process_tx_bit.sv
// process_tx_bit: USB transmit bit engine (SYNC, LSB-first shift, bit stuffing, NRZI, EOP)
//  clk, rst (async active-low)
//  JBit/KBit: line encodings; TxByteIn/TxCtrlIn/txByteWEn/txByteRdy: one-deep byte holding reg
//  TxBitsOut/txBitsWEn/txBitRdy: one line state per handshake; txUnderrun: sticky dry-shift flag
module process_tx_bit
  import process_tx_bit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] JBit,
  input  logic [1:0] KBit,
  input  logic [7:0] TxByteIn,
  input  logic [7:0] TxCtrlIn,
  input  logic       txByteWEn,
  output logic       txByteRdy,
  output logic [1:0] TxBitsOut,
  output logic       txBitsWEn,
  input  logic       txBitRdy,
  output logic       txUnderrun
);
  txState_t state, stateNxt;
  logic hValid, consume, canEmit, wEnNxt, underNxt;
  logic [7:0] hCtrl, hData, shiftReg, shiftNxt;
  logic [3:0] bitCnt, bitCntNxt;
  logic [2:0] onesCnt, onesNxt;
  logic [1:0] seCnt, seCntNxt, lineState, lineNxt, outNxt, flipLine;
  assign txByteRdy = !hValid;
  // a pulse blocks the next cycle so txBitRdy is always re-sampled between bits
  assign canEmit = txBitRdy && !txBitsWEn;
  assign flipLine = lineState == JBit ? KBit : JBit;
  always_comb begin
    stateNxt = state;
    shiftNxt = shiftReg;
    bitCntNxt = bitCnt;
    onesNxt = onesCnt;
    seCntNxt = seCnt;
    lineNxt = lineState;
    outNxt = TxBitsOut;
    wEnNxt = 1'b0;
    underNxt = txUnderrun;
    consume = 1'b0;
    case (state)
      IDLE: if (hValid) begin
        consume = 1'b1;
        if (hCtrl == DATA_START) begin
          lineNxt = JBit;
          shiftNxt = SYNC_BYTE;
          bitCntNxt = 4'd0;
          onesNxt = 3'd0;
          underNxt = 1'b0;
          stateNxt = SEND_BIT;
        end
      end
      SEND_BIT: if (canEmit) begin
        lineNxt = shiftReg[0] ? lineState : flipLine;
        outNxt = lineNxt;
        wEnNxt = 1'b1;
        shiftNxt = shiftReg >> 1;
        bitCntNxt = bitCnt + 4'd1;
        onesNxt = shiftReg[0] ? onesCnt + 3'd1 : 3'd0;
        stateNxt = onesNxt == MAX_ONES ? STUFF : bitCnt == 4'd7 ? LOAD : SEND_BIT;
      end
      STUFF: if (canEmit) begin
        lineNxt = flipLine;
        outNxt = flipLine;
        wEnNxt = 1'b1;
        onesNxt = 3'd0;
        stateNxt = bitCnt == 4'd8 ? LOAD : SEND_BIT;
      end
      LOAD: if (hValid) begin
        consume = 1'b1;
        shiftNxt = hData;
        bitCntNxt = 4'd0;
        seCntNxt = 2'd0;
        // anything other than a stream byte (stop, a stray start, unknown) closes the packet
        stateNxt = hCtrl == DATA_STREAM ? SEND_BIT : EOP_SE0;
      end else begin
        underNxt = 1'b1;
        stateNxt = UNDERRUN_WAIT;
      end
      UNDERRUN_WAIT: stateNxt = hValid ? LOAD : UNDERRUN_WAIT;
      EOP_SE0: if (canEmit) begin
        outNxt = SE0;
        wEnNxt = 1'b1;
        seCntNxt = seCnt + 2'd1;
        stateNxt = seCnt == EOP_SE0_BITS - 2'd1 ? EOP_J : EOP_SE0;
      end
      EOP_J: if (canEmit) begin
        outNxt = JBit;
        lineNxt = JBit;
        wEnNxt = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      hValid <= 1'b0;
      hCtrl <= 8'd0;
      hData <= 8'd0;
      shiftReg <= 8'd0;
      bitCnt <= 4'd0;
      onesCnt <= 3'd0;
      seCnt <= 2'd0;
      lineState <= 2'b00;
      TxBitsOut <= 2'b00;
      txBitsWEn <= 1'b0;
      txUnderrun <= 1'b0;
    end else begin
      state <= stateNxt;
      hValid <= (txByteWEn && !hValid) || (hValid && !consume);
      if (txByteWEn && !hValid) begin
        hCtrl <= TxCtrlIn;
        hData <= TxByteIn;
      end
      shiftReg <= shiftNxt;
      bitCnt <= bitCntNxt;
      onesCnt <= onesNxt;
      seCnt <= seCntNxt;
      lineState <= lineNxt;
      TxBitsOut <= outNxt;
      txBitsWEn <= wEnNxt;
      txUnderrun <= underNxt;
    end
endmodule

// File: tb/tb_process_tx_bit.sv
// tb_process_tx_bit: directed and randomized packets checked against a line-level reference model
module tb_process_tx_bit;
  import process_tx_bit_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] JBit = 2'b10, KBit = 2'b01;
  logic [7:0] TxByteIn = 8'd0, TxCtrlIn = 8'd0;
  logic txByteWEn = 1'b0, txBitRdy = 1'b1, randRdy = 1'b0;
  logic txByteRdy, txBitsWEn, txUnderrun;
  logic [1:0] TxBitsOut, snapOut;
  logic rdyAtEdge = 1'b0, prevWEn = 1'b0;
  int vectors = 0, miscompares = 0, violations = 0, snapN;
  logic [1:0] got[$], expQ[$];
  logic [7:0] pkt[$];

  process_tx_bit dut (
    .clk(clk), .rst(rst), .JBit(JBit), .KBit(KBit), .TxByteIn(TxByteIn), .TxCtrlIn(TxCtrlIn),
    .txByteWEn(txByteWEn), .txByteRdy(txByteRdy), .TxBitsOut(TxBitsOut), .txBitsWEn(txBitsWEn),
    .txBitRdy(txBitRdy), .txUnderrun(txUnderrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdyAtEdge <= txBitRdy;

  always @(negedge clk)
    if (rst) begin
      if (txBitsWEn) got.push_back(TxBitsOut);
      if (txBitsWEn && (prevWEn || !rdyAtEdge)) violations <= violations + 1;
      prevWEn <= txBitsWEn;
    end

  initial forever begin
    @(negedge clk);
    if (randRdy) txBitRdy = $urandom_range(0, 3) != 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // NRZI line states expected for SYNC + pkt, stuffing after six 1s, then SE0,SE0,J
  function automatic void model();
    logic [1:0] line;
    int ones;
    logic [7:0] bytes[$];
    line = JBit;
    ones = 0;
    bytes = pkt;
    bytes.push_front(8'h80);
    expQ.delete();
    foreach (bytes[i])
      for (int b = 0; b < 8; b++) begin
        if (bytes[i][b]) ones++;
        else begin
          line = line == JBit ? KBit : JBit;
          ones = 0;
        end
        expQ.push_back(line);
        if (ones == 6) begin
          line = line == JBit ? KBit : JBit;
          ones = 0;
          expQ.push_back(line);
        end
      end
    expQ.push_back(2'b00);
    expQ.push_back(2'b00);
    expQ.push_back(JBit);
  endfunction

  task automatic sendByte(input logic [7:0] c, input logic [7:0] d);
    int n = 0;
    while (!txByteRdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("byte_rdy_wait", 32'(n < 400), 1);
    TxCtrlIn = c;
    TxByteIn = d;
    txByteWEn = 1'b1;
    @(negedge clk);
    txByteWEn = 1'b0;
  endtask

  task automatic waitBits(input string tag, input int n);
    int c = 0;
    while (got.size() < n && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(got.size() >= n), 1);
  endtask

  task automatic finishPacket(input string tag);
    int c = 0;
    while (got.size() < expQ.size() && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (8) @(negedge clk);
    check({tag, "_len"}, got.size(), expQ.size());
    foreach (expQ[i])
      if (i < got.size()) check($sformatf("%s_bit%0d", tag, i), 32'(got[i]), 32'(expQ[i]));
    check({tag, "_rdy"}, 32'(txByteRdy), 1);
    got.delete();
  endtask

  task automatic runPacket(input string tag);
    model();
    sendByte(DATA_START, 8'h00);
    foreach (pkt[i]) sendByte(DATA_STREAM, pkt[i]);
    sendByte(DATA_STOP, 8'h00);
    finishPacket(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(txByteRdy), 1);
    check("rst_out", 32'(TxBitsOut), 0);
    check("rst_wen", 32'(txBitsWEn), 0);
    check("rst_under", 32'(txUnderrun), 0);
    rst = 1'b1;
    @(negedge clk);
    // byte 8'h00 written out by hand: SYNC KJKJKJKK, eight toggles, SE0 SE0 J
    expQ = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01,
             2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01,
             2'b00, 2'b00, 2'b10};
    sendByte(DATA_START, 8'h00);
    sendByte(DATA_STREAM, 8'h00);
    sendByte(DATA_STOP, 8'h00);
    finishPacket("zero");
    pkt = '{8'hFF};
    runPacket("ones");
    pkt = '{8'h3F};
    runPacket("x3f");
    pkt = '{8'hFC};
    runPacket("stuff_eop");
    pkt = '{8'hFF, 8'hFF, 8'h7E};
    runPacket("multi_stuff");
    sendByte(DATA_STREAM, 8'h55);
    sendByte(DATA_STOP, 8'h00);
    repeat (20) @(negedge clk);
    check("idle_discard", got.size(), 0);
    check("idle_rdy", 32'(txByteRdy), 1);
    pkt = '{8'h96};
    model();
    sendByte(DATA_START, 8'h00);
    sendByte(DATA_STREAM, 8'h96);
    sendByte(DATA_START, 8'h00);
    finishPacket("restart");
    repeat (30) @(negedge clk);
    check("restart_discard", got.size(), 0);
    pkt = '{8'hA5, 8'h3C};
    model();
    sendByte(DATA_START, 8'h00);
    sendByte(DATA_STREAM, 8'hA5);
    waitBits("stall_reach", 12);
    txBitRdy = 1'b0;
    @(negedge clk);
    snapN = got.size();
    snapOut = TxBitsOut;
    repeat (10) begin
      @(negedge clk);
      check("stall_no_strobe", 32'(txBitsWEn), 0);
    end
    check("stall_hold_out", 32'(TxBitsOut), 32'(snapOut));
    check("stall_count", got.size(), snapN);
    txBitRdy = 1'b1;
    sendByte(DATA_STREAM, 8'h3C);
    if (!txByteRdy) begin
      TxCtrlIn = DATA_STOP;
      txByteWEn = 1'b1;
      @(negedge clk);
      txByteWEn = 1'b0;
    end
    sendByte(DATA_STOP, 8'h00);
    finishPacket("stall");
    pkt = '{8'h5A};
    model();
    sendByte(DATA_START, 8'h00);
    sendByte(DATA_STREAM, 8'h5A);
    waitBits("under_reach", 16);
    repeat (10) @(negedge clk);
    check("under_flag", 32'(txUnderrun), 1);
    snapN = got.size();
    repeat (20) @(negedge clk);
    check("under_quiet", got.size(), snapN);
    check("under_bits", snapN, expQ.size() - 3);
    sendByte(DATA_STOP, 8'h00);
    finishPacket("under");
    check("under_sticky", 32'(txUnderrun), 1);
    pkt = '{8'h0F};
    model();
    sendByte(DATA_START, 8'h00);
    repeat (3) @(negedge clk);
    check("under_clear", 32'(txUnderrun), 0);
    sendByte(DATA_STREAM, 8'h0F);
    sendByte(DATA_STOP, 8'h00);
    finishPacket("after_under");
    sendByte(DATA_START, 8'h00);
    sendByte(DATA_STREAM, 8'h11);
    sendByte(DATA_STREAM, 8'h22);
    waitBits("rst_mid_reach", 19);
    rst = 1'b0;
    #1;
    check("rst_mid_rdy", 32'(txByteRdy), 1);
    check("rst_mid_out", 32'(TxBitsOut), 0);
    check("rst_mid_wen", 32'(txBitsWEn), 0);
    check("rst_mid_under", 32'(txUnderrun), 0);
    @(negedge clk);
    rst = 1'b1;
    got.delete();
    @(negedge clk);
    pkt = '{8'hC3};
    runPacket("post_rst");
    randRdy = 1'b1;
    for (int p = 0; p < 8; p++) begin
      int n;
      {JBit, KBit} = $urandom_range(0, 1) != 0 ? 4'b1001 : 4'b0110;
      n = $urandom_range(1, 4);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back($urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom));
      runPacket($sformatf("rand%0d", p));
    end
    randRdy = 1'b0;
    @(negedge clk);
    txBitRdy = 1'b1;
    check("protocol", violations, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
